// File: rtl/lab2_proc_req_squash_tracker.sv
// rtl/lab2_proc_req_squash_tracker.sv - credit-bounded request forwarder that drops stale responses after a squash
// Optional LAB2_PROC_REQ_SQUASH_TRACKER_BYPASS_EN: a returning response frees its credit in the same cycle.
module lab2_proc_req_squash_tracker #(
  parameter  int p_req_nbits    = 77,
  parameter  int p_resp_nbits   = 47,
  parameter  int p_max_inflight = 4,
  localparam int CW             = $clog2(p_max_inflight + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    squash,
  input  logic [p_req_nbits-1:0]  reqin_msg,
  input  logic                    reqin_val,
  output logic                    reqin_rdy,
  output logic [p_req_nbits-1:0]  reqout_msg,
  output logic                    reqout_val,
  input  logic                    reqout_rdy,
  input  logic [p_resp_nbits-1:0] respin_msg,
  input  logic                    respin_val,
  output logic                    respin_rdy,
  output logic [p_resp_nbits-1:0] respout_msg,
  output logic                    respout_val,
  input  logic                    respout_rdy,
  output logic [CW-1:0]           inflight,
  output logic                    draining
);

  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          drop_now;
  logic          can_issue;
  logic          req_go;
  logic          resp_go;

  // A squash discards the response returning in the same cycle, so it joins drop_now directly.
  assign drop_now    = squash || (drop_cnt_q != '0);
  assign respin_rdy  = !reset && (drop_now || respout_rdy);
  assign respout_val = !reset && !drop_now && respin_val;
  assign respout_msg = respin_msg;
  assign resp_go     = respin_val && respin_rdy;

`ifdef LAB2_PROC_REQ_SQUASH_TRACKER_BYPASS_EN
  assign can_issue = (inflight_q < CW'(p_max_inflight)) || resp_go;
`else
  assign can_issue = (inflight_q < CW'(p_max_inflight));
`endif

  assign reqout_val = !reset && reqin_val && can_issue && !squash;
  assign reqin_rdy  = !reset && reqout_rdy && can_issue && !squash;
  assign reqout_msg = reqin_msg;
  assign req_go     = reqout_val && reqout_rdy;

  assign inflight = inflight_q;
  assign draining = (drop_cnt_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;

    if (req_go && !resp_go) begin
      inflight_d = inflight_q + CW'(1);
    end else if (resp_go && !req_go && (inflight_q != '0)) begin
      inflight_d = inflight_q - CW'(1);
    end

    // Squash re-derives the stale count from what stays outstanding past this edge.
    if (squash) begin
      if (resp_go && (inflight_q != '0)) begin
        drop_cnt_d = inflight_q - CW'(1);
      end else begin
        drop_cnt_d = inflight_q;
      end
    end else if (resp_go && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: doc/lab2_proc_req_squash_tracker.md
# lab2_proc_req_squash_tracker

Request-side counterpart to the processor's response drop logic. Sits between the processor's memory request/response ports and the memory. It forwards requests and bounds the number of outstanding requests with a credit counter. On a squash it records how many in-flight responses are now stale, then discards exactly that many as they return. Unlike a single-packet drop, it supports any number of outstanding squashed responses.

## Interface
- p_req_nbits, 77, request message width
- p_resp_nbits, 47, response message width
- p_max_inflight, 4, maximum outstanding requests (≥1); counter width CW = $clog2(p_max_inflight+1)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- squash  input  1  pipeline squash; all responses outstanding at this edge become stale
- reqin_msg  input  p_req_nbits  request from processor
- reqin_val  input  1  request valid
- reqin_rdy  output  1  request ready
- reqout_msg  output  p_req_nbits  request to memory (= reqin_msg)
- reqout_val  output  1  request valid to memory
- reqout_rdy  input  1  memory ready
- respin_msg  input  p_resp_nbits  response from memory
- respin_val  input  1  response valid
- respin_rdy  output  1  response ready
- respout_msg  output  p_resp_nbits  response to processor (= respin_msg)
- respout_val  output  1  response valid to processor
- respout_rdy  input  1  processor ready
- inflight  output  CW  outstanding request count
- draining  output  1  drop_cnt != 0

## Operation

Registers:
- inflight (CW bits)
- drop_cnt (CW bits)

Invariant: drop_cnt ≤ inflight.

Request path:
- can_issue = inflight < p_max_inflight.
- reqout_val = reqin_val && can_issue && !squash.
- reqin_rdy = reqout_rdy && can_issue && !squash.
- A squashed-cycle request is not consumed. Upstream withdraws it.
- req_go = reqout_val && reqout_rdy.

Response path:
- drop_now = squash || drop_cnt != 0.
- When drop_now: respout_val = 0, respin_rdy = 1. The response is consumed and discarded.
- Otherwise: respout_val = respin_val, respin_rdy = respout_rdy.
- resp_go = respin_val && respin_rdy.

inflight update:
- inflight += req_go − resp_go.
- If both fire in the same cycle, inflight is unchanged.
- resp_go with inflight == 0 is a protocol error. inflight saturates at 0 and does not underflow.

drop_cnt update:
- If squash: drop_cnt ← inflight − resp_go (saturating at 0). This counts every response still outstanding after this edge and supersedes any prior drop_cnt.
- Else if resp_go && drop_cnt != 0: drop_cnt ← drop_cnt − 1.

Other rules:
- No request issues in a squash cycle, so newly issued requests are never counted as stale.
- Requests may issue while draining. Their responses arrive after all stale responses (memory is in-order) and pass through normally.

## Timing
- Reset: inflight = 0, drop_cnt = 0, draining = 0. While reset is high, reqin_rdy, reqout_val, respin_rdy and respout_val are all forced to 0.
- Request and response paths have zero latency (combinational forward). The only state is the two counters, updated at posedge.
- A squash drops a response arriving in the same cycle combinationally, with no one-cycle bubble.
- Credit check uses registered inflight. Without bypass, a full tracker needs one cycle after a response before reissuing.
- Back-to-back squashes: each squash recomputes drop_cnt from current inflight.
- Reset mid-drain clears both counters. Responses returning afterward are the environment's responsibility.

## Configuration
- LAB2_PROC_REQ_SQUASH_TRACKER_BYPASS_EN
  - Defined: can_issue = inflight < p_max_inflight || (respin_val && respin_rdy). A response freeing a credit lets a request issue the same cycle. This adds a combinational path respin_val/respout_rdy → reqin_rdy.
  - Undefined: can_issue uses registered inflight only. There is no response-to-request combinational path.

## Test plan
- Pass-through: 8 requests, each response returned one cycle after issue, squash=0 → 8 responses delivered in order; inflight ≤ 1; draining never set.
- Credit limit, p_max_inflight=4, memory holds responses → after 4 issues, reqin_rdy=0 and inflight=4. Release one response → reissue next cycle (same cycle with BYPASS_EN).
- Squash with 3 outstanding, no same-cycle response → drop_cnt=3. Next 3 responses are consumed with respout_val=0. The fourth response (issued post-squash) is delivered; draining falls after the third drop.
- Squash coinciding with a returning response, inflight=2 → that response is dropped and drop_cnt=1. The following response is dropped, then normal operation resumes.
- Squash during drain: drop_cnt=2, one new request issued (inflight=3), squash again → drop_cnt=3; all three responses dropped.
- Reset asserted with inflight=3 and drop_cnt=2 → next cycle inflight=0, drop_cnt=0, draining=0; all handshake outputs 0 during reset.
